// File: rtl/phold_dispatcher.sv
// rtl/phold_dispatcher.sv - pending-event queue and dispatcher feeding one PHOLD core
// Optional COLLECT stall counter: define PHOLD_DISPATCH_STATS_EN.
module phold_dispatcher #(
  parameter int          NIDB       = 3,
  parameter int          NRB        = 8,
  parameter int          QDEPTH     = 16,
  parameter logic [31:0] MAX_EVENTS = 32'd1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_core_ready,
  output logic                         o_core_event_valid,
  output logic [NIDB-1:0]              o_core_event_id,
  output logic [15:0]                  o_core_event_time,
  output logic [15:0]                  o_core_global_time,
  output logic [NRB-1:0]               o_core_random,
  input  logic                         i_core_new_event_ready,
  input  logic [15:0]                  i_core_new_event_time,
  input  logic [NIDB-1:0]              i_core_new_event_target,
  output logic                         o_core_ack,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [31:0]                  o_events_processed,
  output logic [$clog2(QDEPTH+1)-1:0]  o_queue_count,
  output logic                         o_causality_err,
  output logic [31:0]                  o_stat_wait_cycles
);

  localparam int QIW = $clog2(QDEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_DISPATCH, S_COLLECT, S_ACK} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_lfsr;
  logic [NIDB-1:0]     r_init_idx;
  logic                r_valid [QDEPTH];
  logic [NIDB-1:0]     r_id    [QDEPTH];
  logic [15:0]         r_time  [QDEPTH];

  logic                w_sel_found;
  logic [QIW-1:0]      w_sel_idx;
  logic [15:0]         w_sel_time;
  logic [NIDB-1:0]     w_sel_id;
  logic                w_free_found;
  logic [QIW-1:0]      w_free_idx;
  logic                w_dispatch;
  logic                w_capture;
  logic                w_lfsr_fb;
  logic [QIW-1:0]      w_init_slot;

  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_init_slot = QIW'(r_init_idx);
  assign w_dispatch  = (r_state == S_DISPATCH) && i_core_ready && (o_queue_count != '0);
  assign w_capture   = (r_state == S_COLLECT) && i_core_new_event_ready;

  // Strict '<' keeps the earliest index on equal timestamps.
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_sel_time   = '0;
    w_sel_id     = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_valid[i] && (!w_sel_found || (r_time[i] < w_sel_time))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = QIW'(i);
        w_sel_time  = r_time[i];
        w_sel_id    = r_id[i];
      end
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = QIW'(i);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     if (&r_init_idx) w_next = S_IDLE;
      S_IDLE:     if (i_start) w_next = S_DISPATCH;
      S_DISPATCH: begin
        if (o_queue_count == '0) w_next = S_IDLE;
        else if (i_core_ready)   w_next = S_COLLECT;
      end
      S_COLLECT:  if (i_core_new_event_ready) w_next = S_ACK;
      S_ACK:      w_next = (o_events_processed >= MAX_EVENTS) ? S_IDLE : S_DISPATCH;
      default:    w_next = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr             <= LFSR_SEED;
      r_init_idx         <= '0;
      o_core_event_valid <= 1'b0;
      o_core_event_id    <= '0;
      o_core_event_time  <= '0;
      o_core_global_time <= '0;
      o_core_random      <= '0;
      o_core_ack         <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_events_processed <= '0;
      o_queue_count      <= '0;
      o_causality_err    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_id[i]    <= '0;
        r_time[i]  <= '0;
      end
    end else begin
      r_lfsr             <= {r_lfsr[14:0], w_lfsr_fb};
      o_core_event_valid <= w_dispatch;
      o_core_ack         <= w_capture;
      o_busy             <= (w_next == S_DISPATCH) || (w_next == S_COLLECT) || (w_next == S_ACK);
      if ((r_state == S_DISPATCH || r_state == S_ACK) && w_next == S_IDLE)
        o_done <= 1'b1;

      if (r_state == S_INIT) begin
        r_valid[w_init_slot] <= 1'b1;
        r_id[w_init_slot]    <= r_init_idx;
        r_time[w_init_slot]  <= '0;
        r_init_idx           <= r_init_idx + 1'b1;
        o_queue_count        <= o_queue_count + 1'b1;
      end

      if (w_dispatch) begin
        o_core_event_id      <= w_sel_id;
        o_core_event_time    <= w_sel_time;
        o_core_global_time   <= w_sel_time;
        o_core_random        <= r_lfsr[NRB-1:0];
        r_valid[w_sel_idx]   <= 1'b0;
        o_queue_count        <= o_queue_count - 1'b1;
        o_events_processed   <= o_events_processed + 1'b1;
      end

      // Events in the past, or with nowhere to go, are dropped and flagged.
      if (w_capture) begin
        if ((i_core_new_event_time < o_core_global_time) || !w_free_found) begin
          o_causality_err <= 1'b1;
        end else begin
          r_valid[w_free_idx] <= 1'b1;
          r_id[w_free_idx]    <= i_core_new_event_target;
          r_time[w_free_idx]  <= i_core_new_event_time;
          o_queue_count       <= o_queue_count + 1'b1;
        end
      end
    end
  end

`ifdef PHOLD_DISPATCH_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stat_wait_cycles <= '0;
    else if ((r_state == S_COLLECT) && !i_core_new_event_ready && (o_stat_wait_cycles != 32'hFFFF_FFFF))
      o_stat_wait_cycles <= o_stat_wait_cycles + 1'b1;
  end
`else
  assign o_stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_phold_dispatcher.sv
// tb/tb_phold_dispatcher.sv - randomized bench for phold_dispatcher against a slot-array reference model
module tb_phold_dispatcher;

  localparam int          NIDB   = 3;
  localparam int          NRB    = 8;
  localparam int          QDEPTH = 16;
  localparam logic [31:0] MAXEV  = 32'd12;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        core_ready;
  logic        new_rdy;
  logic [15:0] new_time;
  logic [2:0]  new_tgt;

  logic        ev_valid;
  logic [2:0]  ev_id;
  logic [15:0] ev_time;
  logic [15:0] gvt;
  logic [7:0]  rnd;
  logic        ack;
  logic        busy;
  logic        done;
  logic [31:0] events;
  logic [4:0]  qcount;
  logic        cerr;
  logic [31:0] stat;

  phold_dispatcher #(
    .NIDB(NIDB), .NRB(NRB), .QDEPTH(QDEPTH), .MAX_EVENTS(MAXEV), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_core_ready(core_ready),
    .o_core_event_valid(ev_valid), .o_core_event_id(ev_id), .o_core_event_time(ev_time),
    .o_core_global_time(gvt), .o_core_random(rnd),
    .i_core_new_event_ready(new_rdy), .i_core_new_event_time(new_time),
    .i_core_new_event_target(new_tgt),
    .o_core_ack(ack), .o_busy(busy), .o_done(done), .o_events_processed(events),
    .o_queue_count(qcount), .o_causality_err(cerr), .o_stat_wait_cycles(stat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr_prev;
  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst ? SEED : lfsr_step(m_lfsr);
  end

  logic        m_v [QDEPTH];
  logic [2:0]  m_id[QDEPTH];
  logic [15:0] m_t [QDEPTH];
  int          m_count;
  int          m_events;
  int          m_wait;
  logic [15:0] m_gvt;
  logic        m_cerr;

  task automatic model_seed();
    for (int i = 0; i < QDEPTH; i++) begin
      m_v[i]  = (i < (1 << NIDB));
      m_id[i] = 3'(i);
      m_t[i]  = 16'd0;
    end
    m_count = 1 << NIDB;
    m_events = 0;
    m_wait = 0;
    m_gvt = 16'd0;
    m_cerr = 1'b0;
  endtask

  task automatic model_insert(input logic [15:0] t, input logic [2:0] tgt);
    int slot;
    slot = -1;
    for (int i = QDEPTH - 1; i >= 0; i--) if (!m_v[i]) slot = i;
    if (t < m_gvt || slot < 0) begin
      m_cerr = 1'b1;
    end else begin
      m_v[slot] = 1'b1;
      m_id[slot] = tgt;
      m_t[slot] = t;
      m_count++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, ev_valid, 0);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_events"}, events, 0);
    check_eq({tag, "_qcount"}, qcount, 0);
    check_eq({tag, "_cerr"}, cerr, 0);
    check_eq({tag, "_stat"}, stat, 0);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ev_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Compare a dispatch against the model's minimum-time, lowest-slot choice.
  task automatic check_dispatch();
    int sel;
    sel = -1;
    for (int i = 0; i < QDEPTH; i++)
      if (m_v[i] && (sel < 0 || m_t[i] < m_t[sel])) sel = i;
    m_v[sel] = 1'b0;
    m_count--;
    m_events++;
    m_gvt = m_t[sel];
    check_eq("disp_id", ev_id, m_id[sel]);
    check_eq("disp_time", ev_time, m_t[sel]);
    check_eq("disp_gvt", gvt, m_gvt);
    check_eq("disp_random", rnd, m_lfsr_prev[7:0]);
    check_eq("disp_qcount", qcount, m_count);
    check_eq("disp_events", events, m_events);
    check_eq("disp_busy", busy, 1);
  endtask

  task automatic do_reset_and_seed(input string tag);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; core_ready = 1'b0; new_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs(tag);
    end
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check_eq({tag, "_qcount_7"}, qcount, 7);
    @(negedge clk);
    check_eq({tag, "_qcount_seeded"}, qcount, 8);
    check_eq({tag, "_busy_idle"}, busy, 0);
    model_seed();
  endtask

  bit          ok;
  int          d;
  int          extra;
  logic [15:0] t;

  initial begin
    rst = 1'b1; start = 1'b0; core_ready = 1'b0;
    new_rdy = 1'b0; new_time = 16'd0; new_tgt = 3'd0;

    do_reset_and_seed("rst1");

    @(negedge clk);
    start = 1'b1;
    core_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int ev = 0; ev < int'(MAXEV); ev++) begin
      if (m_count == 0) break;
      wait_valid(ok);
      if (!ok) begin
        check_eq("dispatch_timeout", ev_valid, 1);
        break;
      end
      check_dispatch();
      core_ready = 1'b0;

      if (ev == 0) begin
        t = 16'd25;
        new_tgt = 3'd5;
      end else begin
        new_tgt = 3'($urandom_range(0, 7));
        if (ev == 2)
          t = m_gvt;
        else if (m_gvt > 0 && (ev == 4 || $urandom_range(0, 7) == 0))
          t = m_gvt - 16'($urandom_range(1, int'(m_gvt)));
        else
          t = m_gvt + 16'($urandom_range(0, 40));
      end

      d = $urandom_range(0, 4);
      m_wait += d;
      repeat (d) begin
        @(negedge clk);
        check_eq("no_early_ack", ack, 0);
      end
      new_time = t;
      new_rdy = 1'b1;
      @(negedge clk);
      check_eq("ack_high", ack, 1);
      check_eq("valid_one_cycle", ev_valid, 0);
      new_rdy = 1'b0;
      core_ready = 1'b1;
      model_insert(t, new_tgt);
      check_eq("ack_qcount", qcount, m_count);
      check_eq("ack_cerr", cerr, m_cerr);
      @(negedge clk);
      check_eq("ack_one_cycle", ack, 0);
    end

    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ev_valid) extra++;
    end
    check_eq("no_extra_dispatch", extra, 0);
    check_eq("done", done, 1);
    check_eq("busy_after_done", busy, 0);
    check_eq("final_events", events, m_events);
    check_eq("final_qcount", qcount, m_count);
    check_eq("final_cerr", cerr, m_cerr);
`ifdef PHOLD_DISPATCH_STATS_EN
    check_eq("stat_wait", stat, m_wait);
`else
    check_eq("stat_wait", stat, 0);
`endif

    // Reset while the core is presenting a generated event in COLLECT.
    do_reset_and_seed("rst2");
    @(negedge clk);
    start = 1'b1;
    core_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    check_eq("rst2_dispatch_seen", ev_valid, 1);
    if (ok) check_dispatch();
    core_ready = 1'b0;
    repeat (2) @(negedge clk);
    new_time = 16'd40;
    new_tgt = 3'd2;
    new_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("midreset_ack", ack, 0);
      check_eq("midreset_qcount", qcount, 0);
      check_eq("midreset_stat", stat, 0);
    end
    rst = 1'b0;
    new_rdy = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) extra++;
    end
    check_eq("post_reset_no_ack", extra, 0);
    check_eq("post_reset_qcount", qcount, 8);
    check_eq("post_reset_busy", busy, 0);
    check_eq("post_reset_stat", stat, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
